// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED datapath.
//   check_width()     - number of check bits (Hamming bits + overall parity)
//                       for a given data width
//   is_power_of_two() - true for positions that carry a Hamming check bit
//   data_pos()        - codeword position of a data bit (data[0] -> 3)
//   ecc_class_e       - decode outcome
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } ecc_class_e;

  function automatic bit is_power_of_two(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest r with 2^r >= data_w + r + 1, plus one overall-parity bit.
  function automatic int check_width(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r++;
    return r + 1;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int data_pos(input int idx);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int p = 3; p < 256; p++) begin
      if (!is_power_of_two(p) && (pos == 0)) begin
        if (seen == idx) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: combinational SECDED syndrome and classification.
//   data      - raw data word
//   check     - raw check bits, MSB = overall parity
//   syndrome  - Hamming syndrome (position of a single flipped bit)
//   parity    - overall parity of data and check bits (1 = odd error count)
//   ecc_class - CLEAN / SEC / DED
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter  int DATA_W  = 64,
  localparam int CHECK_W = check_width(DATA_W)
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [CHECK_W-1:0] check,
  output logic [CHECK_W-2:0] syndrome,
  output logic               parity,
  output ecc_class_e         ecc_class
);

  localparam int H_W      = CHECK_W - 1;
  localparam int LAST_POS = DATA_W + CHECK_W - 1;

  // Each set data bit contributes its position number; XORing all set
  // positions (check bits sit at 2^i) yields the Hamming syndrome.
  logic [H_W-1:0] pos_term [DATA_W];

  for (genvar g = 0; g < DATA_W; g++) begin : g_pos
    localparam logic [H_W-1:0] POS = H_W'(data_pos(g));
    assign pos_term[g] = data[g] ? POS : '0;
  end

  assign parity = (^data) ^ (^check);

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no latch can be inferred.
  always_comb begin
    syndrome = check[H_W-1:0];
    for (int i = 0; i < DATA_W; i++) syndrome = syndrome ^ pos_term[i];
  end

  // Odd parity with a syndrome inside the codeword is a single error
  // (syndrome 0 means the overall-parity bit itself). Even parity with a
  // non-zero syndrome, or a syndrome pointing past the end, is a double.
  always_comb begin
    ecc_class = CLEAN;
    if (parity) begin
      ecc_class = (32'(syndrome) <= LAST_POS) ? SEC : DED;
    end else if (syndrome != '0) begin
      ecc_class = DED;
    end
  end

endmodule

// File: rtl/ecc_secded_decoder.sv
// ecc_secded_decoder: 2-stage pipelined SECDED decoder with valid/ready.
//   sys_clk, sys_rst_n           - clock, async active-low reset
//   in_valid/in_ready            - input handshake
//   in_data, in_check, in_tag    - raw word, check bits (MSB overall parity), tag
//   out_valid/out_ready          - output handshake
//   out_data, out_tag            - corrected data (raw if uncorrectable), tag
//   out_sec, out_ded             - single corrected / uncorrectable
//   out_syndrome                 - {overall parity mismatch, Hamming syndrome}
//   cnt_clr                      - clears counters and last-error capture
//   corr_count, uncorr_count     - saturating SEC / DED counts
//   last_err_valid/_syndrome/_tag- capture of the most recent error
module ecc_secded_decoder
  import ecc_pkg::*;
#(
  parameter  int DATA_W  = 64,
  parameter  int TAG_W   = 8,
  parameter  int CNT_W   = 16,
  localparam int CHECK_W = check_width(DATA_W)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CHECK_W-1:0] in_check,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_sec,
  output logic               out_ded,
  output logic [CHECK_W-1:0] out_syndrome,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   corr_count,
  output logic [CNT_W-1:0]   uncorr_count,
  output logic               last_err_valid,
  output logic [CHECK_W-1:0] last_err_syndrome,
  output logic [TAG_W-1:0]   last_err_tag
);

  localparam int H_W = CHECK_W - 1;

  // Stage 1: raw word plus syndrome
  logic               s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [CHECK_W-1:0] s1_syn_q, s1_syn_d;
  ecc_class_e         s1_class_q, s1_class_d;

  // Stage 2: registered outputs
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_sec_q, out_sec_d;
  logic               out_ded_q, out_ded_d;
  logic [CHECK_W-1:0] out_syn_q, out_syn_d;

  // Statistics
  logic [CNT_W-1:0]   corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]   uncorr_cnt_q, uncorr_cnt_d;
  logic               lerr_valid_q, lerr_valid_d;
  logic [CHECK_W-1:0] lerr_syn_q, lerr_syn_d;
  logic [TAG_W-1:0]   lerr_tag_q, lerr_tag_d;

  logic [H_W-1:0]     calc_syn;
  logic               calc_parity;
  ecc_class_e         calc_class;

  ecc_syndrome_calc #(.DATA_W(DATA_W)) u_syndrome_calc (
    .data      (in_data),
    .check     (in_check),
    .syndrome  (calc_syn),
    .parity    (calc_parity),
    .ecc_class (calc_class)
  );

  // One-hot flip mask: the data bit whose position equals the syndrome.
  // Check-bit and overall-parity positions match no data bit, so the data
  // passes through unchanged for those single errors.
  logic [DATA_W-1:0] flip_mask;
  for (genvar g = 0; g < DATA_W; g++) begin : g_flip
    localparam logic [H_W-1:0] POS = H_W'(data_pos(g));
    assign flip_mask[g] = (s1_syn_q[H_W-1:0] == POS);
  end

  logic s2_adv, s1_adv, out_hs;
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_q;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_tag_d     = s1_tag_q;
    s1_syn_d     = s1_syn_q;
    s1_class_d   = s1_class_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_sec_d    = out_sec_q;
    out_ded_d    = out_ded_q;
    out_syn_d    = out_syn_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    lerr_valid_d = lerr_valid_q;
    lerr_syn_d   = lerr_syn_q;
    lerr_tag_d   = lerr_tag_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d  = in_data;
        s1_tag_d   = in_tag;
        s1_syn_d   = {calc_parity, calc_syn};
        s1_class_d = calc_class;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = (s1_class_q == SEC) ? (s1_data_q ^ flip_mask) : s1_data_q;
        out_tag_d  = s1_tag_q;
        out_sec_d  = (s1_class_q == SEC);
        out_ded_d  = (s1_class_q == DED);
        out_syn_d  = s1_syn_q;
      end
    end

    // A clear wins over a same-cycle event; that event is not recorded.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      lerr_valid_d = 1'b0;
      lerr_syn_d   = '0;
      lerr_tag_d   = '0;
    end else if (out_hs) begin
      if (out_sec_q && (corr_cnt_q != '1))   corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (out_ded_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      if (out_sec_q || out_ded_q) begin
        lerr_valid_d = 1'b1;
        lerr_syn_d   = out_syn_q;
        lerr_tag_d   = out_tag_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_tag_q     <= '0;
      s1_syn_q     <= '0;
      s1_class_q   <= CLEAN;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_sec_q    <= 1'b0;
      out_ded_q    <= 1'b0;
      out_syn_q    <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      lerr_valid_q <= 1'b0;
      lerr_syn_q   <= '0;
      lerr_tag_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_tag_q     <= s1_tag_d;
      s1_syn_q     <= s1_syn_d;
      s1_class_q   <= s1_class_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_sec_q    <= out_sec_d;
      out_ded_q    <= out_ded_d;
      out_syn_q    <= out_syn_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      lerr_valid_q <= lerr_valid_d;
      lerr_syn_q   <= lerr_syn_d;
      lerr_tag_q   <= lerr_tag_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_tag           = out_tag_q;
  assign out_sec           = out_sec_q;
  assign out_ded           = out_ded_q;
  assign out_syndrome      = out_syn_q;
  assign corr_count        = corr_cnt_q;
  assign uncorr_count      = uncorr_cnt_q;
  assign last_err_valid    = lerr_valid_q;
  assign last_err_syndrome = lerr_syn_q;
  assign last_err_tag      = lerr_tag_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Testbench for ecc_secded_decoder (DATA_W=64, CHECK_W=8, TAG_W=8, CNT_W=4).
// The reference model treats the word as a 72-bit codeword indexed by
// position and decodes by brute force: a codeword is valid when the XOR of
// the positions of its set bits is 0 and its total parity is even; a word is
// correctable when exactly one single-bit flip makes it valid.
module tb_ecc_secded_decoder;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int TW = 8;
  localparam int NW = 4;
  localparam int NPOS = DW + CW;  // positions 0..71, 0 = overall parity

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_check;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_sec, out_ded;
  logic [CW-1:0] out_syndrome;
  logic          cnt_clr;
  logic [NW-1:0] corr_count, uncorr_count;
  logic          last_err_valid;
  logic [CW-1:0] last_err_syndrome;
  logic [TW-1:0] last_err_tag;

  ecc_secded_decoder #(.DATA_W(DW), .TAG_W(TW), .CNT_W(NW)) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_check          (in_check),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_tag           (out_tag),
    .out_sec           (out_sec),
    .out_ded           (out_ded),
    .out_syndrome      (out_syndrome),
    .cnt_clr           (cnt_clr),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count),
    .last_err_valid    (last_err_valid),
    .last_err_syndrome (last_err_syndrome),
    .last_err_tag      (last_err_tag)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          sec;
    logic          ded;
    logic [CW-1:0] syn;
  } exp_t;

  typedef logic [NPOS-1:0] cw_t;

  function automatic cw_t pack(input logic [DW-1:0] d, input logic [CW-1:0] c);
    cw_t cw;
    int  di;
    cw    = '0;
    di    = 0;
    cw[0] = c[CW-1];
    for (int pos = 1; pos < NPOS; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        for (int i = 0; i < CW - 1; i++) if (pos == (1 << i)) cw[pos] = c[i];
      end else begin
        cw[pos] = d[di];
        di++;
      end
    end
    return cw;
  endfunction

  function automatic logic [DW-1:0] unpack_data(input cw_t cw);
    logic [DW-1:0] d;
    int di;
    d  = '0;
    di = 0;
    for (int pos = 3; pos < NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = cw[pos];
        di++;
      end
    end
    return d;
  endfunction

  function automatic logic [CW-1:0] syn_of(input cw_t cw);
    int x;
    x = 0;
    for (int pos = 1; pos < NPOS; pos++) if (cw[pos]) x = x ^ pos;
    return {^cw, x[CW-2:0]};
  endfunction

  function automatic bit cw_ok(input cw_t cw);
    return syn_of(cw) == '0;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic [TW-1:0] t);
    exp_t e;
    cw_t  cw, tmp;
    int   hits;
    cw    = pack(d, c);
    e.tag = t;
    e.syn = syn_of(cw);
    e.sec = 1'b0;
    e.ded = 1'b0;
    e.data = d;
    if (!cw_ok(cw)) begin
      hits = 0;
      for (int k = 0; k < NPOS; k++) begin
        tmp    = cw;
        tmp[k] = ~tmp[k];
        if (cw_ok(tmp)) begin
          hits++;
          e.data = unpack_data(tmp);
        end
      end
      if (hits == 1) e.sec = 1'b1;
      else begin
        e.ded  = 1'b1;
        e.data = d;
      end
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic [CW-1:0] s;
    s = syn_of(pack(d, '0));
    c = {1'b0, s[CW-2:0]};
    c[CW-1] = ^pack(d, c);
    return c;
  endfunction

  // nerr: 0..2 random bit flips of a valid codeword, 3 = random check bits
  task automatic gen_word(input int nerr, output logic [DW-1:0] d, output logic [CW-1:0] c);
    int b0, b1;
    d  = {$urandom, $urandom};
    c  = encode(d);
    b0 = $urandom_range(0, NPOS - 1);
    b1 = (b0 + $urandom_range(1, NPOS - 1)) % NPOS;
    if (nerr >= 1 && nerr <= 2) begin
      if (b0 < DW) d[b0] = ~d[b0]; else c[b0-DW] = ~c[b0-DW];
    end
    if (nerr == 2) begin
      if (b1 < DW) d[b1] = ~d[b1]; else c[b1-DW] = ~c[b1-DW];
    end
    if (nerr == 3) c = CW'($urandom);
  endtask

  // ---------------- scoreboard and cycle driver ----------------
  exp_t          exp_q[$];
  int            m_corr, m_uncorr;
  logic          m_lvalid;
  logic [CW-1:0] m_lsyn;
  logic [TW-1:0] m_ltag;
  int            n_out;

  task automatic model_clear();
    m_corr = 0; m_uncorr = 0; m_lvalid = 1'b0; m_lsyn = '0; m_ltag = '0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_corr_count"},     corr_count,        m_corr);
    check({tag, "_uncorr_count"},   uncorr_count,      m_uncorr);
    check({tag, "_last_err_valid"}, last_err_valid,    m_lvalid);
    check({tag, "_last_err_syn"},   last_err_syndrome, m_lsyn);
    check({tag, "_last_err_tag"},   last_err_tag,      m_ltag);
  endtask

  // Inputs are set by the caller; this task observes the handshakes that
  // the coming clock edge will complete, then advances one cycle.
  task automatic cycle();
    exp_t          e;
    bit            stall, event_seen;
    logic [DW-1:0] held_data;
    logic [CW-1:0] held_syn;
    #1;
    event_seen = cnt_clr;
    check("in_ready", in_ready, !(exp_q.size() == 2 && out_valid && !out_ready));
    stall     = out_valid && !out_ready;
    held_data = out_data;
    held_syn  = out_syndrome;
    if (out_valid && out_ready) begin
      event_seen = 1'b1;
      n_out++;
      if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", out_tag, e.tag);
        check("out_sec", out_sec, e.sec);
        check("out_ded", out_ded, e.ded);
        check("out_syndrome", out_syndrome, e.syn);
        if (!cnt_clr) begin
          if (e.sec && m_corr < 15) m_corr++;
          if (e.ded && m_uncorr < 15) m_uncorr++;
          if (e.sec || e.ded) begin
            m_lvalid = 1'b1; m_lsyn = e.syn; m_ltag = e.tag;
          end
        end
      end
    end
    if (cnt_clr) model_clear();
    if (in_valid && in_ready) exp_q.push_back(model(in_data, in_check, in_tag));
    @(posedge sys_clk);
    #1;
    if (stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, held_data);
      check("hold_syndrome", out_syndrome, held_syn);
    end
    if (event_seen) check_stats("stats");
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = '0; in_check = '0; in_tag = '0;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    exp_q.delete();
    model_clear();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", {out_sec, out_ded, out_syndrome}, 0);
    check("rst_in_ready", in_ready, 1'b1);
    check_stats("rst");
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chk;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp_data;
    logic          exp_sec;
    logic          exp_ded;
    logic [CW-1:0] exp_syn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    int            lat, n0;

    vecs[0] = '{64'h0,                 8'h00, 8'h01, 64'h0, 1'b0, 1'b0, 8'h00}; // clean
    vecs[1] = '{64'h1,                 8'h00, 8'h02, 64'h0, 1'b1, 1'b0, 8'h83}; // data[0]
    vecs[2] = '{64'h3,                 8'h00, 8'h03, 64'h3, 1'b0, 1'b1, 8'h06}; // double
    vecs[3] = '{64'h0,                 8'h80, 8'h04, 64'h0, 1'b1, 1'b0, 8'h80}; // overall bit
    vecs[4] = '{64'h0,                 8'h01, 8'h05, 64'h0, 1'b1, 1'b0, 8'h81}; // check[0]
    vecs[5] = '{64'h0,                 8'h7F, 8'h06, 64'h0, 1'b0, 1'b1, 8'hFF}; // beyond end
    vecs[6] = '{64'h8000000000000000, 8'h00, 8'h07, 64'h0, 1'b1, 1'b0, 8'hC7}; // data[63]
    vecs[7] = '{64'h0,                 8'h40, 8'h08, 64'h0, 1'b1, 1'b0, 8'hC0}; // check[6]

    n_out = 0;
    do_reset();

    // Directed vectors, one at a time, with latency measurement.
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_check = vecs[i].chk; in_tag = vecs[i].tag;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        cycle();
        lat++;
      end
      check("latency", lat, 2);
      check("tbl_data", out_data, vecs[i].exp_data);
      check("tbl_tag", out_tag, vecs[i].tag);
      check("tbl_sec", out_sec, vecs[i].exp_sec);
      check("tbl_ded", out_ded, vecs[i].exp_ded);
      check("tbl_syndrome", out_syndrome, vecs[i].exp_syn);
      cycle();
    end
    check("tbl_corr_count", corr_count, 4'd5);
    check("tbl_uncorr_count", uncorr_count, 4'd2);
    check("tbl_last_err_syn", last_err_syndrome, 8'hC0);
    check("tbl_last_err_tag", last_err_tag, 8'h08);

    // Backpressure: 8 words streamed while out_ready toggles.
    n0 = n_out;
    begin
      int sent;
      sent = 0;
      for (int cyc = 0; cyc < 100 && (sent < 8 || exp_q.size() != 0); cyc++) begin
        out_ready = cyc[0];
        in_valid  = (sent < 8);
        if (sent < 8) begin
          gen_word($urandom_range(0, 2), d, c);
          in_data = d; in_check = c; in_tag = 8'h40 + 8'(sent);
        end
        #1;
        if (in_valid && in_ready) sent++;
        cycle();
      end
    end
    check("bp_words_out", n_out - n0, 8);
    drain();

    // Randomized traffic with random stalls and occasional clears.
    for (int cyc = 0; cyc < 400; cyc++) begin
      gen_word($urandom_range(0, 3), d, c);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d; in_check = c; in_tag = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    cnt_clr = 1'b0;
    drain();

    // Saturation: clear, then 17 single-error words.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("clr_corr_count", corr_count, 4'h0);
    for (int i = 0; i < 17; i++) begin
      gen_word(1, d, c);
      in_valid = 1'b1; in_data = d; in_check = c; in_tag = 8'h80 + 8'(i);
      out_ready = 1'b1;
      cycle();
    end
    drain();
    check("sat_corr_count", corr_count, 4'hF);
    check("sat_uncorr_count", uncorr_count, 4'h0);

    // One DED counted, then a DED handshake coinciding with cnt_clr.
    gen_word(2, d, c);
    in_valid = 1'b1; in_data = d; in_check = c; in_tag = 8'hD0;
    cycle();
    drain();
    check("ded_uncorr_count", uncorr_count, 4'h1);
    out_ready = 1'b0;
    gen_word(2, d, c);
    in_valid = 1'b1; in_data = d; in_check = c; in_tag = 8'hD1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    check("clr_ded_out_valid", out_valid, 1'b1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("clr_ded_uncorr", uncorr_count, 4'h0);
    check("clr_ded_corr", corr_count, 4'h0);
    check("clr_ded_lvalid", last_err_valid, 1'b0);

    // Reset in the middle of a stream, then resume without draining.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen_word(1, d, c);
      in_valid = 1'b1; in_data = d; in_check = c; in_tag = 8'hE0 + 8'(i);
      cycle();
    end
    do_reset();
    gen_word(0, d, c);
    in_valid = 1'b1; in_data = d; in_check = c; in_tag = 8'hEE; out_ready = 1'b1;
    cycle();
    drain();
    check("post_rst_words_out", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecc_secded_decoder.md
Name: ecc_secded_decoder

Overview:
Parametrised, pipelined SECDED (Hamming plus overall parity) decoder for the memory read-return path; supersedes the fixed 64+8 parity-compare checker. Takes a data word and its check bits with valid/ready flow control. Corrects single-bit errors, flags double-bit errors, and keeps saturating error counters and a last-error capture for the CSR block.

Parameters:
DATA_W, 64, data width; legal values 8/16/32/64.
CHECK_W, derived (5/6/7/8), check bits; localparam from ecc_pkg, not overridable.
TAG_W, 8, opaque sideband tag (e.g. read ID) carried alongside the word.
CNT_W, 16, width of each error counter.

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  async active-low reset
in_valid  in  1  input word valid
in_ready  out  1  decoder can accept
in_data  in  DATA_W  raw data
in_check  in  CHECK_W  raw check bits; MSB = overall parity
in_tag  in  TAG_W  sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  corrected data (raw data if uncorrectable)
out_tag  out  TAG_W  tag, aligned with out_data
out_sec  out  1  single error corrected
out_ded  out  1  uncorrectable error
out_syndrome  out  CHECK_W  {overall parity mismatch, Hamming syndrome}
cnt_clr  in  1  synchronous clear of counters and capture
corr_count  out  CNT_W  saturating count of SEC events
uncorr_count  out  CNT_W  saturating count of DED events
last_err_valid  out  1  capture registers hold an error
last_err_syndrome  out  CHECK_W  syndrome of most recent error
last_err_tag  out  TAG_W  tag of most recent error

Behaviour:
- Code layout: positions 1..DATA_W+CHECK_W-1; powers of two hold in_check[i] at position 2^i (i < CHECK_W-1); data bits fill remaining positions ascending (data[0] at position 3). in_check[CHECK_W-1] = XOR of all other data and check bits.
- Syndrome s[i] = in_check[i] XOR data bits whose position has bit i set. p = XOR of all data and check bits.
- Classification: s=0,p=0 clean. p=1,s=0: overall-parity bit error; data unchanged; out_sec=1. p=1, s in a valid position: flip that bit; out_sec=1 (check-bit position: data unchanged). p=0,s!=0: out_ded=1. p=1, s beyond last position: out_ded=1. out_sec and out_ded never both set.
- Pipeline: 2 stages. S1 registers data, tag, syndrome, p. S2 registers corrected data and flags. Latency is 2 cycles from input handshake to out_valid with no backpressure.
- Flow control: S2 advances when !out_valid || out_ready. S1 advances when S2 advances or S1 is empty. in_ready = !s1_valid || s2_advance (bubbles collapse). Full throughput of 1 word/cycle. Outputs hold stable while out_valid && !out_ready.
- Counters and capture update only on an output handshake (out_valid && out_ready).
  - SEC increments corr_count; DED increments uncorr_count; both saturate at all-ones.
  - Any error loads last_err_syndrome and last_err_tag and sets last_err_valid.
  - cnt_clr has priority over a same-cycle increment or capture: the result is 0/invalid and that event is dropped.
- Reset: all valids, counters, capture and flag outputs go to 0. out_data, out_tag and out_syndrome go to 0. In-flight words are discarded. Reset mid-stream requires no drain.

Decomposition:
- ecc_pkg holds:
  - check_width(DATA_W) function
  - data-index-to-position map function
  - is_power_of_two helper
  - classification enum {CLEAN, SEC, DED}
- Natural sub-module: ecc_syndrome_calc. It is combinational: data and check in, syndrome, p and class out. It is reused later by the matching encoder testbench.

Test Plan:
- Clean word: in_data=64'h0, in_check=8'h00 -> 2 cycles later out_data=0, out_sec=0, out_ded=0, counters unchanged.
- Single data error: in_data=64'h1, check=8'h00 (data[0] at position 3) -> out_syndrome=8'h83, out_data=0, out_sec=1, corr_count=1, last_err_syndrome=8'h83.
- Double error: in_data=64'h3, check=8'h00 (positions 3,5) -> syndrome=8'h06, out_ded=1, out_data=64'h3 raw, uncorr_count=1.
- Overall parity flip: in_data=0, check=8'h80 -> out_sec=1, out_data=0, syndrome=8'h80.
- Backpressure: stream 8 words with out_ready toggling 1/0 -> output order and data unchanged, no drop/duplicate, in_ready low only when both stages are full and stalled.
- Saturation/clear: CNT_W=4, 17 SEC words -> corr_count=4'hF. Then cnt_clr asserted on the same cycle as a DED handshake -> uncorr_count=0, last_err_valid=0.
